// File: rtl/exa_traffic_producer_with_vcs_if.sv
// ExaNet-style three-phase stream: header, payload and footer beats share one
// 128-bit data bus, each phase with its own valid/ready pair.
interface exanet;
    logic         header_valid;
    logic         payload_valid;
    logic         footer_valid;
    logic [127:0] data;
    logic         header_ready;
    logic         payload_ready;
    logic         footer_ready;

    modport master (
        output header_valid,
        output payload_valid,
        output footer_valid,
        output data,
        input  header_ready,
        input  payload_ready,
        input  footer_ready
    );

    modport slave (
        input  header_valid,
        input  payload_valid,
        input  footer_valid,
        input  data,
        output header_ready,
        output payload_ready,
        output footer_ready
    );
endinterface

// File: rtl/exa_traffic_producer_with_vcs.sv
// Packet generator cycling round-robin over vc_num*prio_num streams, emitting
// header / payload_flits payload beats / footer per packet with per-stream sequence numbers.
module exa_traffic_producer_with_vcs #(
    parameter int unsigned prio_num      = 2,
    parameter int unsigned vc_num        = 2,
    parameter int unsigned payload_flits = 16,
    localparam int unsigned S = vc_num * prio_num,
    localparam int unsigned W = (S > 1) ? $clog2(S) : 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_enable,
    input  logic [S-1:0] i_stream_mask,
    input  logic [15:0]  i_pkt_limit,
    input  logic [3:0]   i_gap,
    exanet.master        exa,
    output logic [W-1:0] o_stream_id,
    output logic [31:0]  o_pkt_count,
    output logic         o_done
);

    typedef enum logic [2:0] {
        StIdle,
        StHeader,
        StPayload,
        StFooter,
        StGap,
        StDone
    } state_e;

    localparam logic [7:0] TagHeader  = 8'hAA;
    localparam logic [7:0] TagPayload = 8'h55;
    localparam logic [7:0] TagFooter  = 8'hFF;
    localparam logic [7:0] LastFlit   = 8'(payload_flits);

    state_e         state_q;
    logic           header_valid_q;
    logic           payload_valid_q;
    logic           footer_valid_q;
    logic [127:0]   data_q;
    logic [W-1:0]   stream_q;
    logic [W-1:0]   rr_q;
    logic [7:0]     flit_q;
    logic [3:0]     gap_q;
    logic [31:0]    pkt_count_q;
    logic           done_q;
    logic [15:0]    seq_q [S];

    logic [S-1:0]   elig;
    logic           any_elig;
    logic [W-1:0]   grant;
    logic [W-1:0]   cand;
    logic [15:0]    cur_seq;
    logic           no_work;

    function automatic logic [127:0] beat(logic [7:0] tag, logic [W-1:0] id,
                                          logic [15:0] seq, logic [7:0] idx);
        return {tag, 8'(id), seq, idx, 88'h0};
    endfunction

    always_comb begin
        elig = '0;
        for (int unsigned s = 0; s < S; s++) begin
            elig[s] = i_stream_mask[s] && ((i_pkt_limit == 16'd0) || (seq_q[s] < i_pkt_limit));
        end
    end

    // Search starts one past the last served stream so every eligible stream gets a turn.
    always_comb begin
        grant    = '0;
        cand     = '0;
        any_elig = 1'b0;
        for (int unsigned i = 1; i <= S; i++) begin
            cand = W'((32'(rr_q) + i) % S);
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                grant    = cand;
            end
        end
    end

    assign cur_seq = seq_q[stream_q];
    assign no_work = (i_pkt_limit != 16'd0) && !any_elig;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= StIdle;
            header_valid_q  <= 1'b0;
            payload_valid_q <= 1'b0;
            footer_valid_q  <= 1'b0;
            data_q          <= '0;
            stream_q        <= '0;
            rr_q            <= W'(S - 1);
            flit_q          <= '0;
            gap_q           <= '0;
            pkt_count_q     <= '0;
            done_q          <= 1'b0;
            for (int unsigned s = 0; s < S; s++) begin
                seq_q[s] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (no_work) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end else if (i_enable && any_elig) begin
                        state_q        <= StHeader;
                        stream_q       <= grant;
                        rr_q           <= grant;
                        header_valid_q <= 1'b1;
                        data_q         <= beat(TagHeader, grant, seq_q[grant], 8'd0);
                    end
                end
                StHeader: begin
                    if (exa.header_ready) begin
                        state_q         <= StPayload;
                        header_valid_q  <= 1'b0;
                        payload_valid_q <= 1'b1;
                        flit_q          <= 8'd1;
                        data_q          <= beat(TagPayload, stream_q, cur_seq, 8'd1);
                    end
                end
                StPayload: begin
                    if (exa.payload_ready) begin
                        if (flit_q == LastFlit) begin
                            state_q         <= StFooter;
                            payload_valid_q <= 1'b0;
                            footer_valid_q  <= 1'b1;
                            data_q          <= beat(TagFooter, stream_q, cur_seq, LastFlit);
                        end else begin
                            flit_q <= flit_q + 8'd1;
                            data_q <= beat(TagPayload, stream_q, cur_seq, flit_q + 8'd1);
                        end
                    end
                end
                StFooter: begin
                    if (exa.footer_ready) begin
                        footer_valid_q   <= 1'b0;
                        data_q           <= '0;
                        seq_q[stream_q]  <= cur_seq + 16'd1;
                        pkt_count_q      <= pkt_count_q + 32'd1;
                        if (i_gap != 4'd0) begin
                            state_q <= StGap;
                            gap_q   <= i_gap;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StGap: begin
                    if (gap_q <= 4'd1) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                StDone: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign exa.header_valid  = header_valid_q;
    assign exa.payload_valid = payload_valid_q;
    assign exa.footer_valid  = footer_valid_q;
    assign exa.data          = data_q;
    assign o_stream_id       = stream_q;
    assign o_pkt_count       = pkt_count_q;
    assign o_done            = done_q;

endmodule

// File: doc/exa_traffic_producer_with_vcs.md
EXA_TRAFFIC_PRODUCER_WITH_VCS -- requirements
Module: exa_traffic_producer_with_vcs

Interface
REQ-001 SHALL have parameter prio_num, default 2, priority levels per VC.
REQ-002 SHALL have parameter vc_num, default 2, virtual channels; streams S = vc_num*prio_num, stream id width W = $clog2(S).
REQ-003 SHALL have parameter payload_flits, default 16, payload flits per packet (1..255).
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_enable  input  1  start/continue packet generation.
REQ-007 SHALL have port i_stream_mask  input  S  bit s=1 makes stream s eligible.
REQ-008 SHALL have port i_pkt_limit  input  16  packets per stream; 0 = unlimited.
REQ-009 SHALL have port i_gap  input  4  idle cycles inserted after each footer.
REQ-010 SHALL have port exa  exanet.master  -  header_valid/payload_valid/footer_valid out 1, data out 128, header_ready/payload_ready/footer_ready in 1.
REQ-011 SHALL have port o_stream_id  output  W  stream of packet in flight.
REQ-012 SHALL have port o_pkt_count  output  32  total footers accepted.
REQ-013 SHALL have port o_done  output  1  all masked streams reached i_pkt_limit.

Function
REQ-014 SHALL implement FSM states IDLE, HEADER, PAYLOAD, FOOTER, GAP, DONE.
REQ-015 IDLE: if i_enable=1 and an eligible stream exists (mask bit set, and limit=0 or seq[s]<limit) SHALL select it round-robin starting after last served stream and enter HEADER next cycle; o_stream_id updated same edge.
REQ-016 IDLE: if i_pkt_limit!=0 and no masked stream has seq<limit SHALL enter DONE; DONE holds until reset, o_done=1 only in DONE.
REQ-017 Exactly one of header/payload/footer_valid SHALL be high, only in HEADER/PAYLOAD/FOOTER respectively; none in IDLE, GAP, DONE.
REQ-018 Valid SHALL stay high and data/o_stream_id SHALL stay constant until matching ready=1; transfer occurs on cycle with valid&ready.
REQ-019 HEADER transfer -> PAYLOAD with flit index k=1; each payload transfer increments k; transfer at k=payload_flits -> FOOTER.
REQ-020 FOOTER transfer -> GAP if i_gap!=0 else IDLE; same edge seq[o_stream_id] +1 (16-bit, wraps 0xFFFF->0) and o_pkt_count +1 (wraps).
REQ-021 GAP SHALL last exactly i_gap cycles (value sampled on footer transfer) then enter IDLE.
REQ-022 Header data: [127:120]=8'hAA, [119:112]=stream id zero-extended, [111:96]=seq[s], [95:0]=0.
REQ-023 Payload flit k data: [127:120]=8'h55, [119:112]=stream id, [111:96]=seq[s], [95:88]=k, [87:0]=0.
REQ-024 Footer data: [127:120]=8'hFF, [119:112]=stream id, [111:96]=seq[s], [95:88]=payload_flits, [87:0]=0.
REQ-025 i_enable deasserted mid-packet SHALL NOT abort; packet completes, FSM then waits in IDLE.
REQ-026 i_stream_mask and i_pkt_limit SHALL be evaluated only in IDLE; changes during a packet take effect at next IDLE.
REQ-027 Minimum spacing: at least one IDLE cycle between footer transfer and next header_valid.
REQ-028 Round-robin pointer SHALL wrap from S-1 to 0; single eligible stream is reselected every packet.

Reset
REQ-029 resetn=0 SHALL immediately force state IDLE, all valids 0, data 0, o_stream_id 0, o_pkt_count 0, o_done 0, all seq[s] 0, round-robin pointer to S-1 (first grant stream 0).
REQ-030 Reset asserted mid-packet SHALL drop the partial packet; no resumption after release.

Verification
REQ-031 Defaults, mask=4'hF, limit=1, gap=0, ready=1 -> 4 packets streams 0,1,2,3 in order, 18 beats each, then o_done=1, o_pkt_count=4.
REQ-032 Ready random (~50%) -> data stable under stall, every header/payload/footer matches REQ-022..024, no beat lost or duplicated.
REQ-033 mask=4'b0100, limit=3 -> three stream-2 packets, seq 0,1,2 in header [111:96], then DONE.
REQ-034 gap=5, ready=1 -> exactly 5 GAP + 1 IDLE cycles between footer transfer and next header_valid.
REQ-035 resetn pulsed low during payload flit 7 -> valids drop asynchronously; after release first header is stream 0, seq 0.
REQ-036 i_enable dropped during PAYLOAD, limit=0 -> packet finishes with footer, then no further valid until i_enable=1.
